// File: rtl/r4_bfly_pkg.sv
// r4_bfly_pkg: shared state enum, width helpers and the output scaler for the
// streaming radix-4 butterfly. out_width() follows the R4_BFLY_SCALE_EN macro.
package r4_bfly_pkg;

  typedef enum logic [1:0] {StLoad, StCalc1, StCalc2, StDrain} state_e;

  // Widest component supported; width-specific views slice from this template.
  localparam int unsigned MaxW = 16;

  typedef struct packed {
    logic signed [MaxW-1:0] re;
    logic signed [MaxW-1:0] im;
  } cplx_t;

  // First-stage sums/differences carry one growth bit.
  function automatic int unsigned sum_width(int unsigned w);
    return w + 1;
  endfunction

  // Final 4-point results carry two growth bits and cannot overflow.
  function automatic int unsigned res_width(int unsigned w);
    return w + 2;
  endfunction

  function automatic int unsigned out_width(int unsigned w);
`ifdef R4_BFLY_SCALE_EN
    return w;
`else
    return w + 2;
`endif
  endfunction

  // Divide by 4 rounding half up, then clamp to a signed w-bit range.
  function automatic int scale_sat(int v, int unsigned w);
    int t;
    int lim;
    t   = (v + 2) >>> 2;
    lim = 1 << (w - 1);
    if (t > lim - 1) return lim - 1;
    if (t < -lim) return -lim;
    return t;
  endfunction

endpackage

// File: rtl/r4_bfly_core.sv
// r4_bfly_core: two registered stages of the 4-point DFT/IDFT. Stage one forms
// a+/-c and b+/-d; stage two combines them, with the multiply-by-j sign picked by inv.
module r4_bfly_core
  import r4_bfly_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                calc1_en,
  input  logic                calc2_en,
  input  logic                inv,
  input  logic signed [W-1:0] x_re [4],
  input  logic signed [W-1:0] x_im [4],
  output logic signed [W+1:0] y_re [4],
  output logic signed [W+1:0] y_im [4]
);

  localparam int unsigned SW = sum_width(W);
  localparam int unsigned RW = res_width(W);

  logic signed [SW-1:0] p_re, p_im, q_re, q_im, r_re, r_im, s_re, s_im;
  logic signed [RW-1:0] qmjs_re, qmjs_im, qpjs_re, qpjs_im;
  logic signed [RW-1:0] x1_re, x1_im, x3_re, x3_im;

  // Stage one: p=a+c, q=a-c, r=b+d, s=b-d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0; p_im <= '0; q_re <= '0; q_im <= '0;
      r_re <= '0; r_im <= '0; s_re <= '0; s_im <= '0;
    end else if (calc1_en) begin
      p_re <= SW'(x_re[0]) + SW'(x_re[2]);
      p_im <= SW'(x_im[0]) + SW'(x_im[2]);
      q_re <= SW'(x_re[0]) - SW'(x_re[2]);
      q_im <= SW'(x_im[0]) - SW'(x_im[2]);
      r_re <= SW'(x_re[1]) + SW'(x_re[3]);
      r_im <= SW'(x_im[1]) + SW'(x_im[3]);
      s_re <= SW'(x_re[1]) - SW'(x_re[3]);
      s_im <= SW'(x_im[1]) - SW'(x_im[3]);
    end
  end

  // Twiddle by +/-j: j*s = (-s_im, s_re); inverse swaps the X1/X3 forms
  always_comb begin
    qmjs_re = RW'(q_re) + RW'(s_im);
    qmjs_im = RW'(q_im) - RW'(s_re);
    qpjs_re = RW'(q_re) - RW'(s_im);
    qpjs_im = RW'(q_im) + RW'(s_re);
    x1_re   = inv ? qpjs_re : qmjs_re;
    x1_im   = inv ? qpjs_im : qmjs_im;
    x3_re   = inv ? qmjs_re : qpjs_re;
    x3_im   = inv ? qmjs_im : qpjs_im;
  end

  // Stage two: register the four bins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        y_re[i] <= '0;
        y_im[i] <= '0;
      end
    end else if (calc2_en) begin
      y_re[0] <= RW'(p_re) + RW'(r_re);
      y_im[0] <= RW'(p_im) + RW'(r_im);
      y_re[2] <= RW'(p_re) - RW'(r_re);
      y_im[2] <= RW'(p_im) - RW'(r_im);
      y_re[1] <= x1_re;
      y_im[1] <= x1_im;
      y_re[3] <= x3_re;
      y_im[3] <= x3_im;
    end
  end

endmodule

// File: rtl/r4_bfly_stream.sv
// r4_bfly_stream: serial-in/serial-out radix-4 butterfly. Four input beats fill a
// frame buffer, the core computes over two cycles, then four bins drain under
// valid/ready. Define R4_BFLY_SCALE_EN for rounded, saturated W-bit outputs.
module r4_bfly_stream
  import r4_bfly_pkg::*;
#(
  parameter int unsigned W = 4,
  localparam int unsigned OW = out_width(W)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 inv_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [W-1:0]  in_re_i,
  input  logic signed [W-1:0]  in_im_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [OW-1:0] out_re_o,
  output logic signed [OW-1:0] out_im_o,
  output logic [1:0]           out_idx_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  state_e state_q, state_d;
  logic [1:0] cnt_q, k_q;
  logic inv_q;
  logic signed [W-1:0] x_re_q [4];
  logic signed [W-1:0] x_im_q [4];
  logic signed [W+1:0] y_re [4];
  logic signed [W+1:0] y_im [4];
  logic signed [W+1:0] res_re, res_im;
  logic in_fire, out_fire;

  assign in_ready_o  = (state_q == StLoad);
  assign out_valid_o = (state_q == StDrain);
  assign out_idx_o   = k_q;
  assign out_last_o  = out_valid_o && (k_q == 2'd3);
  assign busy_o      = (state_q != StLoad) || (cnt_q != 2'd0);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // Next state; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_fire && cnt_q == 2'd3) state_d = StCalc1;
      StCalc1: state_d = StCalc2;
      StCalc2: state_d = StDrain;
      StDrain: if (out_fire && out_last_o) state_d = StLoad;
      default: state_d = StLoad;
    endcase
    if (flush_i) state_d = StLoad;
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= StLoad;
    else            state_q <= state_d;
  end

  // Beat counters, inverse flag (taken with beat 0) and input frame buffer
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
      k_q   <= '0;
      inv_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_re_q[i] <= '0;
        x_im_q[i] <= '0;
      end
    end else if (flush_i) begin
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      if (in_fire) begin
        x_re_q[cnt_q] <= in_re_i;
        x_im_q[cnt_q] <= in_im_i;
        if (cnt_q == 2'd0) inv_q <= inv_i;
        cnt_q <= cnt_q + 2'd1;
      end
      if (out_fire) k_q <= k_q + 2'd1;
    end
  end

  r4_bfly_core #(
    .W(W)
  ) u_core (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .calc1_en (state_q == StCalc1),
    .calc2_en (state_q == StCalc2),
    .inv      (inv_q),
    .x_re     (x_re_q),
    .x_im     (x_im_q),
    .y_re     (y_re),
    .y_im     (y_im)
  );

  // Present bin k while draining, zero otherwise
  always_comb begin
    res_re   = y_re[k_q];
    res_im   = y_im[k_q];
    out_re_o = '0;
    out_im_o = '0;
    if (state_q == StDrain) begin
`ifdef R4_BFLY_SCALE_EN
      out_re_o = OW'(scale_sat(int'(res_re), W));
      out_im_o = OW'(scale_sat(int'(res_im), W));
`else
      out_re_o = res_re;
      out_im_o = res_im;
`endif
    end
  end

endmodule

// File: tb/tb_r4_bfly_stream.sv
// tb_r4_bfly_stream: directed self-checking bench for r4_bfly_stream (W=4),
// expected bins hand-computed; R4_BFLY_SCALE_EN selects scaled expectations.
module tb_r4_bfly_stream;

  localparam int unsigned W = 4;
`ifdef R4_BFLY_SCALE_EN
  localparam int unsigned OW = W;
`else
  localparam int unsigned OW = W + 2;
`endif

  logic wb_clk_i = 1'b0;
  logic wb_rst_ni = 1'b1;
  logic inv_i = 1'b0;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic signed [W-1:0] in_re_i = '0;
  logic signed [W-1:0] in_im_i = '0;
  logic in_ready_o, out_valid_o, out_last_o, busy_o;
  logic signed [OW-1:0] out_re_o, out_im_o;
  logic [1:0] out_idx_o;

  int checks = 0;
  int failures = 0;
  int stim_re[4], stim_im[4], exp_re[4], exp_im[4];
  int got_re[4], got_im[4], got_idx[4];
  logic got_v[4], got_last[4];

  always #5 wb_clk_i = ~wb_clk_i;

  r4_bfly_stream #(
    .W(W)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .inv_i       (inv_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_re_i     (in_re_i),
    .in_im_i     (in_im_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_re_o    (out_re_o),
    .out_im_o    (out_im_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  // Reference output mapping of a full-precision bin value
  function automatic int model_out(int raw);
`ifdef R4_BFLY_SCALE_EN
    int t;
    t = (raw + 2) >>> 2;
    if (t > 7) t = 7;
    if (t < -8) t = -8;
    return t;
`else
    return raw;
`endif
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic set_stim(int ar, int ai, int br, int bi, int cr, int ci, int dr, int di);
    stim_re[0] = ar; stim_im[0] = ai; stim_re[1] = br; stim_im[1] = bi;
    stim_re[2] = cr; stim_im[2] = ci; stim_re[3] = dr; stim_im[3] = di;
  endtask

  task automatic set_exp(int r0, int i0, int r1, int i1, int r2, int i2, int r3, int i3);
    exp_re[0] = model_out(r0); exp_im[0] = model_out(i0);
    exp_re[1] = model_out(r1); exp_im[1] = model_out(i1);
    exp_re[2] = model_out(r2); exp_im[2] = model_out(i2);
    exp_re[3] = model_out(r3); exp_im[3] = model_out(i3);
  endtask

  // Drive 'beats' input beats; inv only holds its value on beat 0
  task automatic send_frame(logic inv, int beats);
    for (int n = 0; n < beats; n++) begin
      int guard = 0;
      in_valid_i = 1'b1;
      in_re_i    = W'(stim_re[n]);
      in_im_i    = W'(stim_im[n]);
      inv_i      = (n == 0) ? inv : ~inv;
      #1;
      while (!in_ready_o && guard < 20) begin
        tick();
        #1;
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        failures++;
        $display("FAIL send_timeout beat %0d in_ready=%0b want 1", n, in_ready_o);
      end
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  // Collect the four output beats with the sink always ready
  task automatic capture_frame();
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int guard = 0;
      #1;
      while (!out_valid_o && guard < 20) begin
        tick();
        #1;
        guard++;
      end
      got_v[k]    = out_valid_o;
      got_re[k]   = int'(out_re_o);
      got_im[k]   = int'(out_im_o);
      got_idx[k]  = int'(out_idx_o);
      got_last[k] = out_last_o;
      tick();
    end
  endtask

  task automatic test_reset();
    #1 wb_rst_ni = 1'b0;
    #2;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid_o); end
    checks++; if (out_re_o !== '0 || out_im_o !== '0) begin failures++; $display("FAIL reset_out_data got %0d,%0d want 0,0", out_re_o, out_im_o); end
    checks++; if (out_idx_o !== 2'd0 || out_last_o !== 1'b0) begin failures++; $display("FAIL reset_idx_last got %0d,%0b want 0,0", out_idx_o, out_last_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    tick();
    tick();
    wb_rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    set_stim(1, 0, 0, 0, 0, 0, 0, 0);
    set_exp(1, 0, 1, 0, 1, 0, 1, 0);
    send_frame(1'b0, 4);
    #1;
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL impulse_calc1 valid=%0b busy=%0b want 0,1", out_valid_o, busy_o); end
    tick(); #1;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL impulse_calc2 valid=%0b want 0", out_valid_o); end
    tick(); #1;
    checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL impulse_latency valid=%0b want 1", out_valid_o); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_v[k] !== 1'b1 || got_idx[k] != k || got_last[k] !== (k == 3)) begin
        failures++;
        $display("FAIL impulse_ctl[%0d] got v=%0b idx=%0d last=%0b want 1,%0d,%0b", k, got_v[k], got_idx[k], got_last[k], k, k == 3);
      end
      checks++;
      if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
        failures++;
        $display("FAIL impulse_bin[%0d] got %0d,%0d want %0d,%0d", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
    #1;
    checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL impulse_return ready=%0b busy=%0b want 1,0", in_ready_o, busy_o); end
  endtask

  task automatic test_dc();
    set_stim(3, 0, 3, 0, 3, 0, 3, 0);
    set_exp(12, 0, 0, 0, 0, 0, 0, 0);
    send_frame(1'b0, 4);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_v[k] !== 1'b1 || got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
        failures++;
        $display("FAIL dc_bin[%0d] got v=%0b %0d,%0d want 1 %0d,%0d", k, got_v[k], got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_twiddle();
    for (int m = 0; m < 2; m++) begin
      set_stim(0, 0, 1, 0, 0, 0, 0, 0);
      if (m == 0) set_exp(1, 0, 0, -1, -1, 0, 0, 1);
      else        set_exp(1, 0, 0, 1, -1, 0, 0, -1);
      send_frame(m[0], 4);
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_v[k] !== 1'b1 || got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
          failures++;
          $display("FAIL twiddle_inv%0d_bin[%0d] got v=%0b %0d,%0d want 1 %0d,%0d", m, k, got_v[k], got_re[k], got_im[k], exp_re[k], exp_im[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    set_stim(7, 0, 0, 7, -8, 0, 0, -8);
    set_exp(-1, -1, 30, 0, -1, 1, 0, 0);
    send_frame(1'b0, 4);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_v[k] !== 1'b1 || got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
        failures++;
        $display("FAIL sat_bin[%0d] got v=%0b %0d,%0d want 1 %0d,%0d", k, got_v[k], got_re[k], got_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int guard = 0;
    set_stim(1, 2, 3, -1, -2, 0, 0, 1);
    set_exp(2, 2, 1, -1, -4, 2, 5, 5);
    send_frame(1'b0, 4);
    out_ready_i = 1'b1;
    #1;
    while (!out_valid_o && guard < 20) begin tick(); #1; guard++; end
    tick();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_re_i     = 4'sd7;
    in_im_i     = -4'sd8;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || out_idx_o !== 2'd1 || in_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_ctl cyc%0d got v=%0b idx=%0d rdy=%0b want 1,1,0", c, out_valid_o, out_idx_o, in_ready_o);
      end
      checks++;
      if (int'(out_re_o) != exp_re[1] || int'(out_im_o) != exp_im[1]) begin
        failures++;
        $display("FAIL bp_hold_data cyc%0d got %0d,%0d want %0d,%0d", c, out_re_o, out_im_o, exp_re[1], exp_im[1]);
      end
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if (out_idx_o != 2'(k) || int'(out_re_o) != exp_re[k] || int'(out_im_o) != exp_im[k]) begin
        failures++;
        $display("FAIL bp_bin[%0d] got idx=%0d %0d,%0d want %0d %0d,%0d", k, out_idx_o, out_re_o, out_im_o, k, exp_re[k], exp_im[k]);
      end
      tick();
    end
    #1;
    checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_no_stray_beat busy=%0b ready=%0b want 0,1", busy_o, in_ready_o); end
  endtask

  // Abort mid-DRAIN at idx 2 via flush (mode 0) or async reset (mode 1)
  task automatic test_abort(int mode);
    int guard = 0;
    if (mode == 0) begin
      set_stim(5, 5, 5, 5, 0, 0, 0, 0);
      send_frame(1'b0, 2);
      #1;
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL flush_partial_busy got %0b want 1", busy_o); end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_partial_clear busy=%0b want 0", busy_o); end
    end
    set_stim(1, 2, 3, -1, -2, 0, 0, 1);
    send_frame(1'b0, 4);
    out_ready_i = 1'b1;
    #1;
    while (!out_valid_o && guard < 20) begin tick(); #1; guard++; end
    tick();
    tick();
    #1;
    checks++; if (out_idx_o !== 2'd2 || out_valid_o !== 1'b1) begin failures++; $display("FAIL abort%0d_at_idx2 got idx=%0d v=%0b want 2,1", mode, out_idx_o, out_valid_o); end
    if (mode == 0) begin
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
    end else begin
      wb_rst_ni = 1'b0;
      #1;
    end
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL abort%0d_state got v=%0b rdy=%0b busy=%0b want 0,1,0", mode, out_valid_o, in_ready_o, busy_o);
    end
    if (mode == 1) begin
      tick();
      wb_rst_ni = 1'b1;
      tick();
    end
    set_stim(2, 0, 2, 0, 2, 0, 2, 0);
    set_exp(8, 0, 0, 0, 0, 0, 0, 0);
    send_frame(1'b0, 4);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_v[k] !== 1'b1 || got_idx[k] != k || got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
        failures++;
        $display("FAIL abort%0d_next_bin[%0d] got v=%0b idx=%0d %0d,%0d want 1 %0d %0d,%0d", mode, k, got_v[k], got_idx[k], got_re[k], got_im[k], k, exp_re[k], exp_im[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_twiddle();
    test_saturation();
    test_back_to_back_backpressure();
    test_abort(0);
    test_abort(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
